// File: rtl/cfg_mem_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_mem_bank_pkg
// Description : Shared types and constants for the memory-bank programming
//               controller.
//               - cfg_mb_state_t : controller state encoding
//               - SETUP_CYCLES   : bit-line setup cycles before a word-line pulse
//               - HOLD_CYCLES    : bit-line hold cycles after a word-line pulse
//               - row_cnt_width(): width of the row counter for a row count
//               Optional feature macro: CFG_MEM_BANK_PARITY_EN (adds S_ERR).
// Revision    : 1.0 - initial release
// ============================================================================
package cfg_mem_bank_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_HOLD  = 3'd4,
`ifdef CFG_MEM_BANK_PARITY_EN
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
`else
        S_DONE  = 3'd5
`endif
    } cfg_mb_state_t;

    localparam int SETUP_CYCLES = 1;
    localparam int HOLD_CYCLES  = 1;

    // A single row still needs a one-bit counter.
    function automatic int row_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_mem_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cfg_mem_bank_ctrl_if
// Description : Bundle between the bitstream loader and the memory-bank
//               controller: start pulse, valid/ready word stream, bit-line and
//               word-line drive, and status flags.
//               master : loader side (drives start/cfg_valid/cfg_data)
//               slave  : controller side (drives cfg_ready/bl/wl/status)
//               Optional feature macro: CFG_MEM_BANK_PARITY_EN (adds cfg_parity).
// Revision    : 1.0 - initial release
// ============================================================================
interface cfg_mem_bank_ctrl_if #(
    parameter int NUM_BL = 4,
    parameter int NUM_WL = 8
) ();
    logic              start;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [NUM_BL-1:0] cfg_data;
`ifdef CFG_MEM_BANK_PARITY_EN
    logic              cfg_parity;
`endif
    logic [NUM_BL-1:0] bl;
    logic [NUM_WL-1:0] wl;
    logic              busy;
    logic              cfg_done;
    logic              cfg_error;

    modport master (
        output start, cfg_valid, cfg_data,
`ifdef CFG_MEM_BANK_PARITY_EN
        output cfg_parity,
`endif
        input  cfg_ready, bl, wl, busy, cfg_done, cfg_error
    );

    modport slave (
        input  start, cfg_valid, cfg_data,
`ifdef CFG_MEM_BANK_PARITY_EN
        input  cfg_parity,
`endif
        output cfg_ready, bl, wl, busy, cfg_done, cfg_error
    );
endinterface
`default_nettype wire

// File: rtl/cfg_wl_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cfg_wl_decoder
// Description : Combinational row index to one-hot word-line decode.
//               i_row : row index
//               i_en  : decode enable (output all-zero when low)
//               o_wl  : one-hot word-line vector (zero when disabled or when
//                       the index is out of range)
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_wl_decoder #(
    parameter int NUM_WL = 8,
    parameter int ROW_W  = 3
) (
    input  wire logic [ROW_W-1:0]  i_row,
    input  wire logic              i_en,
    output logic      [NUM_WL-1:0] o_wl
);
    always_comb begin
        o_wl = '0;
        for (int i = 0; i < NUM_WL; i++) begin
            o_wl[i] = i_en && (i_row == ROW_W'(i));
        end
    end
endmodule
`default_nettype wire

// File: rtl/cfg_mem_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cfg_mem_bank_ctrl
// Description : Memory-bank programming sequencer for a configuration array.
//               Per row: LOAD (accept word) -> SETUP -> PULSE (word line high
//               for WL_PULSE_CYCLES) -> HOLD, then next row or DONE.
//               prog_clk : programming clock
//               pReset   : asynchronous active-high reset
//               bus      : cfg_mem_bank_ctrl_if.slave (start, stream, bl/wl,
//                          busy, cfg_done, cfg_error)
//               Optional feature macro: CFG_MEM_BANK_PARITY_EN - even parity
//               check on each accepted word; a mismatch parks in S_ERR.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_mem_bank_ctrl
    import cfg_mem_bank_pkg::*;
#(
    parameter int NUM_BL          = 4,
    parameter int NUM_WL          = 8,
    parameter int WL_PULSE_CYCLES = 2
) (
    input  wire logic         prog_clk,
    input  wire logic         pReset,
    cfg_mem_bank_ctrl_if.slave bus
);
    localparam int c_ROW_W   = row_cnt_width(NUM_WL);
    // One phase counter serves SETUP, PULSE and HOLD; size it for the longest.
    localparam int c_CNT_MAX = (WL_PULSE_CYCLES > SETUP_CYCLES) ?
                               ((WL_PULSE_CYCLES > HOLD_CYCLES) ? WL_PULSE_CYCLES : HOLD_CYCLES) :
                               ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_ROW_W-1:0] c_LAST_ROW    = c_ROW_W'(NUM_WL - 1);
    localparam logic [c_CNT_W-1:0] c_SETUP_LAST  = c_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LAST  = c_CNT_W'(WL_PULSE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST   = c_CNT_W'(HOLD_CYCLES - 1);

    cfg_mb_state_t       r_state;
    logic [c_ROW_W-1:0]  r_row;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [NUM_BL-1:0]   r_bl;
    logic [NUM_WL-1:0]   r_wl;
    logic                r_cfg_ready;
    logic                r_busy;
    logic                r_cfg_done;
    logic                r_cfg_error;

    logic                w_accept;
    logic                w_dec_en;
    logic [NUM_WL-1:0]   w_wl_onehot;

    // r_cfg_ready is registered, so the handshake never looks through to cfg_valid.
    assign w_accept = bus.cfg_valid && r_cfg_ready;
    assign w_dec_en = (r_state == S_SETUP);

    cfg_wl_decoder #(
        .NUM_WL (NUM_WL),
        .ROW_W  (c_ROW_W)
    ) u_wl_dec (
        .i_row  (r_row),
        .i_en   (w_dec_en),
        .o_wl   (w_wl_onehot)
    );

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_cnt       <= '0;
            r_bl        <= '0;
            r_wl        <= '0;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_done  <= 1'b0;
            r_cfg_error <= 1'b0;
        end else begin
            case (r_state)
                // Idle and both terminal states only react to start.
`ifdef CFG_MEM_BANK_PARITY_EN
                S_IDLE, S_DONE, S_ERR: begin
`else
                S_IDLE, S_DONE: begin
`endif
                    if (bus.start) begin
                        r_state     <= S_LOAD;
                        r_row       <= '0;
                        r_cnt       <= '0;
                        r_cfg_ready <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cfg_done  <= 1'b0;
                        r_cfg_error <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (w_accept) begin
                        r_cfg_ready <= 1'b0;
                        r_cnt       <= '0;
`ifdef CFG_MEM_BANK_PARITY_EN
                        if (bus.cfg_parity != (^bus.cfg_data)) begin
                            r_state     <= S_ERR;
                            r_cfg_error <= 1'b1;
                            r_busy      <= 1'b0;
                            r_bl        <= '0;
                        end else begin
                            r_bl    <= bus.cfg_data;
                            r_state <= S_SETUP;
                        end
`else
                        r_bl    <= bus.cfg_data;
                        r_state <= S_SETUP;
`endif
                    end
                end

                S_SETUP: begin
                    if (r_cnt == c_SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_wl    <= w_wl_onehot;
                        r_state <= S_PULSE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_PULSE: begin
                    if (r_cnt == c_PULSE_LAST) begin
                        r_cnt   <= '0;
                        r_wl    <= '0;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        r_cnt <= '0;
                        if (r_row == c_LAST_ROW) begin
                            r_state    <= S_DONE;
                            r_cfg_done <= 1'b1;
                            r_busy     <= 1'b0;
                            r_bl       <= '0;
                        end else begin
                            r_row       <= r_row + 1'b1;
                            r_state     <= S_LOAD;
                            r_cfg_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_wl        <= '0;
                    r_cfg_ready <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_ready = r_cfg_ready;
    assign bus.bl        = r_bl;
    assign bus.wl        = r_wl;
    assign bus.busy      = r_busy;
    assign bus.cfg_done  = r_cfg_done;
`ifdef CFG_MEM_BANK_PARITY_EN
    assign bus.cfg_error = r_cfg_error;
`else
    assign bus.cfg_error = 1'b0;
`endif

endmodule
`default_nettype wire
